// File: rtl/mem_responder_pkg.sv
// Shared request/response bundles and responder register types.
// Imported by mem_responder, mem_array and the bench.
package mem_responder_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mem_resp_state_type;

  typedef struct packed {
    mem_resp_state_type state;
    logic [3:0]         counter;
    logic               ready;
    logic [31:0]        rdata;
  } mem_resp_reg_type;

  localparam mem_resp_reg_type init_mem_resp_reg = '{
    state:   IDLE,
    counter: 4'h0,
    ready:   1'b0,
    rdata:   32'h0
  };

endpackage

// File: rtl/mem_array.sv
// Single-port word SRAM with byte-lane write enables.
// Combinational read; the caller registers the result.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clock,
  input  logic [3:0]            wen,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory target: answers core requests from an on-chip SRAM with wait states.
// Define MEM_WPROT_EN to drop writes to word indices below PROT_WORDS.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_STATES = 1,
  parameter int PROT_WORDS  = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  mem_in,
  output mem_out_type mem_out
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  mem_resp_reg_type r;
  mem_resp_reg_type rin;

  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           arr_rdata;
  logic [3:0]            wen;
  logic                  is_write;
  logic                  wr_ok;

  logic unused_addr;
  assign unused_addr = ^{mem_in.mem_addr[31:DEPTH_LOG2+2],
                         mem_in.mem_addr[1:0]};

  assign idx      = mem_in.mem_addr[DEPTH_LOG2+1:2];
  assign is_write = (mem_in.mem_wstrb != 4'h0) && !mem_in.mem_instr;

`ifdef MEM_WPROT_EN
  assign wr_ok = !(32'(idx) < PROT_WORDS);
`else
  localparam int unused_prot_words = PROT_WORDS;
  assign wr_ok = 1'b1;
`endif

  always_comb begin
    rin = r;
    wen = 4'h0;
    unique case (r.state)
      IDLE: begin
        if (mem_in.mem_valid) begin
          rin.state   = BUSY;
          rin.counter = WS;
        end
      end
      BUSY: begin
        if (r.counter != 4'h0) begin
          rin.counter = r.counter - 4'd1;
        end else begin
          rin.state = DONE;
          rin.ready = 1'b1;
          if (is_write) begin
            wen       = wr_ok ? mem_in.mem_wstrb : 4'h0;
            rin.rdata = 32'h0;
          end else begin
            rin.rdata = arr_rdata;
          end
        end
      end
      DONE: begin
        // valid seen here still belongs to the request just acknowledged
        rin.state = IDLE;
        rin.ready = 1'b0;
        rin.rdata = 32'h0;
      end
      default: rin = init_mem_resp_reg;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r <= init_mem_resp_reg;
    end else begin
      r <= rin;
    end
  end

  mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clock(clock),
    .wen  (wen),
    .addr (idx),
    .wdata(mem_in.mem_wdata),
    .rdata(arr_rdata)
  );

  assign mem_out.mem_ready = r.ready;
  assign mem_out.mem_rdata = r.rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: WAIT_STATES=1 and WAIT_STATES=0 instances.
// Build with MEM_WPROT_EN to also exercise write protection.
module tb_mem_responder;
  import mem_responder_pkg::*;

`ifdef MEM_WPROT_EN
  localparam logic [31:0] BASE = 32'h0000_2000;
`else
  localparam logic [31:0] BASE = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  mem_in_type  in1;
  mem_in_type  in0;
  mem_out_type out1;
  mem_out_type out0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .DEPTH_LOG2(12), .WAIT_STATES(1), .PROT_WORDS(1024)
  ) dut1 (
    .clock(clk), .reset(rst_n), .mem_in(in1), .mem_out(out1)
  );

  mem_responder #(
    .DEPTH_LOG2(12), .WAIT_STATES(0), .PROT_WORDS(1024)
  ) dut0 (
    .clock(clk), .reset(rst_n), .mem_in(in0), .mem_out(out0)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    logic [31:0] exp;
  } vec_t;

  vec_t v[14];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic txn(input bit sel, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     input logic instr, output logic [31:0] rd,
                     output int lat);
    mem_in_type q;
    logic rdy;
    q.mem_valid = 1'b1;
    q.mem_instr = instr;
    q.mem_addr  = a;
    q.mem_wdata = d;
    q.mem_wstrb = s;
    if (sel) in1 = q;
    else in0 = q;
    lat = -1;
    rd  = '0;
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      rdy = sel ? out1.mem_ready : out0.mem_ready;
      if (rdy) begin
        lat = n;
        rd  = sel ? out1.mem_rdata : out0.mem_rdata;
        break;
      end
    end
    if (sel) in1 = '0;
    else in0 = '0;
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: no mem_ready at addr %h", a);
    end
    @(negedge clk);
    check("ready_clear", 32'(sel ? out1.mem_ready : out0.mem_ready), 32'h0);
    check("rdata_clear", sel ? out1.mem_rdata : out0.mem_rdata, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] old;
    int          lat;
    logic        exp_rdy;

    v[0]  = '{"wr_10",     BASE+32'h10,   32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
    v[1]  = '{"rd_10",     BASE+32'h10,   32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
    v[2]  = '{"wr_20_all", BASE+32'h20,   32'hAAAAAAAA, 4'hF, 1'b0, 32'h0};
    v[3]  = '{"wr_20_0101",BASE+32'h20,   32'h11223344, 4'h5, 1'b0, 32'h0};
    v[4]  = '{"rd_20_a",   BASE+32'h20,   32'h0,        4'h0, 1'b0, 32'hAA22AA44};
    v[5]  = '{"wr_20_1010",BASE+32'h20,   32'h55667788, 4'hA, 1'b0, 32'h0};
    v[6]  = '{"rd_20_b",   BASE+32'h20,   32'h0,        4'h0, 1'b0, 32'h55227744};
    v[7]  = '{"wr_04",     BASE+32'h4,    32'h0,        4'hF, 1'b0, 32'h0};
    v[8]  = '{"wr_wrap",   BASE+32'h4004, 32'h00000055, 4'h1, 1'b0, 32'h0};
    v[9]  = '{"rd_04_wrap",BASE+32'h4,    32'h0,        4'h0, 1'b0, 32'h00000055};
    v[10] = '{"instr_wr",  BASE+32'h10,   32'h12345678, 4'hF, 1'b1, 32'hDEADBEEF};
    v[11] = '{"rd_13",     BASE+32'h13,   32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
    v[12] = '{"wr_30",     BASE+32'h30,   32'h12345678, 4'hF, 1'b0, 32'h0};
    v[13] = '{"rd_30",     BASE+32'h30,   32'h0,        4'h0, 1'b0, 32'h12345678};

    in1 = '0;
    in0 = '0;
    @(negedge clk);
    check("rst_ready1", 32'(out1.mem_ready), 32'h0);
    check("rst_rdata1", out1.mem_rdata, 32'h0);
    check("rst_ready0", 32'(out0.mem_ready), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      txn(1'b1, v[i].addr, v[i].wdata, v[i].wstrb, v[i].instr, rd, lat);
      check({v[i].name, "_lat"}, 32'(lat), 32'd2);
      check(v[i].name, rd, v[i].exp);
    end

    // reset in the BUSY cycle of a write must leave the array alone
    in1.mem_valid = 1'b1;
    in1.mem_instr = 1'b0;
    in1.mem_addr  = BASE + 32'h30;
    in1.mem_wdata = 32'hFFFFFFFF;
    in1.mem_wstrb = 4'hF;
    @(negedge clk);
    check("abort_busy_ready", 32'(out1.mem_ready), 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_rst_ready", 32'(out1.mem_ready), 32'h0);
    rst_n = 1'b1;
    in1 = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_after_ready", 32'(out1.mem_ready), 32'h0);
    end
    txn(1'b1, BASE + 32'h30, 32'h0, 4'h0, 1'b0, rd, lat);
    check("abort_rd_30", rd, 32'h12345678);

    // zero wait states, request held across two acknowledges
    txn(1'b0, BASE + 32'h10, 32'hCAFE1234, 4'hF, 1'b0, rd, lat);
    check("ws0_wr_lat", 32'(lat), 32'd1);
    in0.mem_valid = 1'b1;
    in0.mem_instr = 1'b0;
    in0.mem_addr  = BASE + 32'h10;
    in0.mem_wdata = 32'h0;
    in0.mem_wstrb = 4'h0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_rdy = (c == 1) || (c == 4);
      check($sformatf("chain_ready_c%0d", c), 32'(out0.mem_ready),
            32'(exp_rdy));
      check($sformatf("chain_rdata_c%0d", c), out0.mem_rdata,
            exp_rdy ? 32'hCAFE1234 : 32'h0);
      if (c == 5) in0 = '0;
    end

`ifdef MEM_WPROT_EN
    txn(1'b1, 32'h100, 32'h0, 4'h0, 1'b0, old, lat);
    txn(1'b1, 32'h100, 32'hCAFEF00D, 4'hF, 1'b0, rd, lat);
    check("prot_wr_lat", 32'(lat), 32'd2);
    check("prot_wr_rdata", rd, 32'h0);
    txn(1'b1, 32'h100, 32'h0, 4'h0, 1'b0, rd, lat);
    check("prot_rd_old", rd, old);
    checks++;
    if (rd === 32'hCAFEF00D) begin
      errors++;
      $display("FAIL prot_not_written: got %h required not cafef00d", rd);
    end
    txn(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 1'b0, rd, lat);
    check("unprot_wr_rdata", rd, 32'h0);
    txn(1'b1, 32'h1000, 32'h0, 4'h0, 1'b0, rd, lat);
    check("unprot_rd", rd, 32'hCAFEF00D);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Target side of the core's memory request protocol (mem_in_type / mem_out_type): the core issues requests, this block answers them.
- Serves instruction fetches and data loads/stores from an on-chip word-organised SRAM, with a configurable number of wait states.
- Used as the tightly-coupled memory in simulation tops and small FPGA builds.
- Produces exactly one single-cycle mem_ready pulse per accepted request.

Parameters:
- DEPTH_LOG2, 12, log2 of the number of 32-bit words in the array (default 16 KiB).
- WAIT_STATES, 1, extra cycles inserted before mem_ready; legal range 0..15.
- PROT_WORDS, 1024, number of write-protected low words; used only with MEM_WPROT_EN.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- mem_in  input  70 (mem_in_type)  request from the core: mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb.
- mem_out  output  33 (mem_out_type)  response to the core: mem_ready, mem_rdata.

Behaviour:
- Protocol: the initiator holds mem_valid and all request fields stable until it samples mem_ready=1. It may change or drop the request at the edge after the ready cycle.
- Request kind: mem_wstrb==0 is a read; mem_wstrb!=0 is a write.
- Addressing:
  - Word index = mem_addr[DEPTH_LOG2+1:2].
  - mem_addr[1:0] and bits above the index are ignored, so addresses beyond the array wrap.
- mem_instr is informational only. An instruction request with nonzero wstrb is treated as a read.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: on a sampled mem_valid=1, load counter=WAIT_STATES and go to BUSY.
  - BUSY, counter!=0: decrement the counter.
  - BUSY, counter==0: perform the access, register mem_ready=1, go to DONE.
    - Read: mem_rdata = array word.
    - Write: byte lanes i with wstrb[i]=1 take wdata[8i+7:8i]; mem_rdata=0.
  - DONE: clear mem_ready and mem_rdata, go to IDLE. The mem_valid sampled in DONE is ignored, because it is still the completed request.
- Latency:
  - mem_ready is high during cycle WAIT_STATES+1, counting from the first cycle mem_valid is sampled.
  - mem_ready is high for exactly one cycle.
  - Back-to-back request period is WAIT_STATES+3 cycles.
- mem_valid falling while in BUSY is a protocol violation. The access still completes and is acknowledged.
- The write is committed only at the BUSY→DONE edge. A read issued immediately after a write to the same word returns the new data.
- Reset (asynchronous, active-low):
  - state=IDLE, counter=0, mem_ready=0, mem_rdata=0.
  - Array contents are not reset.
  - Reset asserted during BUSY aborts the request; no array write occurs.
- Outputs are registered only; there is no combinational path from mem_in to mem_out.

Optional Feature:
- Macro MEM_WPROT_EN.
- Defined: a write whose word index is < PROT_WORDS is dropped.
  - The array is unchanged.
  - The request is still acknowledged with normal timing and mem_rdata=0.
  - Reads are unaffected.
- Undefined: all writes are committed, and PROT_WORDS is unused.

Decomposition:
- In the shared wires package:
  - mem_resp_state_type enum {IDLE, BUSY, DONE}.
  - mem_resp_reg_type struct (state, counter[3:0], ready, rdata), with init_mem_resp_reg: all zero, state=IDLE.
- Reuse the existing mem_in_type and mem_out_type unchanged.
- One sub-module, mem_array:
  - Single-port, DEPTH_LOG2-deep, 32-bit array with a 4-bit byte-write enable.
  - Synchronous write; read captured into the response register at the same edge.
- The FSM and response register stay in mem_responder.

Test Plan:
- WAIT_STATES=1, read of addr 0x00000010 preloaded with 0xDEADBEEF → mem_ready high in cycle 2 only, mem_rdata=0xDEADBEEF, then 0 in cycle 3.
- Write addr 0x20, wdata 0x11223344, wstrb 4'b0101, over prior word 0xAAAAAAAA → read of 0x20 returns 0xAA22AA44; the write acknowledgement carries mem_rdata=0.
- WAIT_STATES=0, mem_valid held continuously with two chained reads → ready pulses in cycles 1 and 4, and the held request is never acknowledged twice.
- DEPTH_LOG2=12, write 0x55 via wstrb 4'b0001 to addr 0x00004004 → read of addr 0x4 returns low byte 0x55 (wrap-around).
- Reset pulled low in the BUSY cycle of a write to 0x30 → mem_ready stays 0, and a later read of 0x30 returns the old contents.
- MEM_WPROT_EN defined, PROT_WORDS=1024:
  - Write 0xCAFEF00D to addr 0x100 → acknowledged, but a read of 0x100 returns the old value.
  - Same write to addr 0x1000 → committed.
